// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage in front of a 16-bit word memory.
//
// Issues one read per granted cycle at the PC. The registered read data
// (MemVal) comes back the next cycle and goes into a small prefetch FIFO
// together with its PC. Decode drains the FIFO through a valid/ready handshake.
// A Redirect drops every buffered word and the in-flight word, then restarts
// fetch at RedirectPC.
//
// Optional build macro: FETCH_STATS_EN adds the FetchCount and FlushCount
// saturating counters.
//
// Ports:
//   clock, reset             clock; synchronous active-high reset
//   MemGrant                 memory port free for fetch this cycle
//   FetchAddr / FetchReq     read address (PC register) / fetch strobe (comb)
//   MemVal                   read data, valid the cycle after FetchReq
//   InstrOut/InstrPC/InstrValid, InstrReady   FIFO head handshake to decode
//   Redirect / RedirectPC    flush and restart fetch at RedirectPC
//   FetchCount, FlushCount   (FETCH_STATS_EN) issue count / discarded words
module fetch_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        MemGrant,
  output logic [15:0] FetchAddr,
  output logic        FetchReq,
  input  logic [15:0] MemVal,
  output logic [15:0] InstrOut,
  output logic [15:0] InstrPC,
  output logic        InstrValid,
  input  logic        InstrReady,
  input  logic        Redirect,
  input  logic [15:0] RedirectPC
`ifdef FETCH_STATS_EN
  ,
  output logic [15:0] FetchCount,
  output logic [15:0] FlushCount
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_W = DEPTH[CW:0];

  logic [15:0]   pc_q, pc_d;
  logic [15:0]   inflight_pc_q, inflight_pc_d;
  logic          inflight_q, inflight_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [15:0]   data_q  [DEPTH];
  logic [15:0]   pcmem_q [DEPTH];

  logic [CW:0]   occ;
  logic          issue, push, pop;

  // The in-flight word already owns a slot, so it counts against capacity.
  // A pop in the same cycle is not credited, which keeps the FetchReq path
  // independent of InstrReady.
  assign occ   = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
  assign issue = MemGrant & ~Redirect & ~reset & (occ < DEPTH_W);
  assign push  = inflight_q;
  assign pop   = (count_q != '0) & InstrReady & ~Redirect;

  assign FetchReq   = issue;
  assign FetchAddr  = pc_q;
  assign InstrValid = (count_q != '0) & ~reset;
  assign InstrOut   = InstrValid ? data_q[rd_ptr_q]  : 16'h0000;
  assign InstrPC    = InstrValid ? pcmem_q[rd_ptr_q] : 16'h0000;

  always_comb begin
    pc_d          = pc_q;
    inflight_pc_d = inflight_pc_q;
    inflight_d    = issue;
    rd_ptr_d      = rd_ptr_q + AW'(pop);
    wr_ptr_d      = wr_ptr_q + AW'(push);
    count_d       = count_q + CW'(push) - CW'(pop);
    if (issue) begin
      inflight_pc_d = pc_q;
      pc_d          = pc_q + 16'h0001;  // natural 16-bit wrap
    end
    if (Redirect) begin
      pc_d       = RedirectPC;
      inflight_d = 1'b0;  // the next MemVal belongs to the old stream
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      inflight_pc_q <= 16'h0000;
      inflight_q    <= 1'b0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      pc_q          <= pc_d;
      inflight_pc_q <= inflight_pc_d;
      inflight_q    <= inflight_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
    end
  end

  // Storage needs no reset: it is only visible through a non-zero count.
  always_ff @(posedge clock) begin
    if (!reset && !Redirect && push) begin
      data_q[wr_ptr_q]  <= MemVal;
      pcmem_q[wr_ptr_q] <= inflight_pc_q;
    end
  end

`ifdef FETCH_STATS_EN
  logic [15:0] fetch_cnt_q, flush_cnt_q;
  logic [16:0] flush_sum;

  assign flush_sum = {1'b0, flush_cnt_q} + {{(16 - CW){1'b0}}, occ};

  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_cnt_q <= 16'h0000;
      flush_cnt_q <= 16'h0000;
    end else begin
      if (issue && fetch_cnt_q != 16'hFFFF) fetch_cnt_q <= fetch_cnt_q + 16'h0001;
      if (Redirect) flush_cnt_q <= flush_sum[16] ? 16'hFFFF : flush_sum[15:0];
    end
  end

  assign FetchCount = fetch_cnt_q;
  assign FlushCount = flush_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit. Two instances share their stimulus: u0 uses
// RESET_PC=0 and u1 uses RESET_PC=FFFE to exercise PC wrap. Each instance
// has a behavioural synchronous-read memory.
module tb_fetch_unit;
  logic        clock = 1'b0;
  logic        reset = 1'b1, MemGrant = 1'b0, InstrReady = 1'b0, Redirect = 1'b0;
  logic [15:0] RedirectPC = 16'h0000;

  logic [15:0] addr0, mv0, out0, pc0, addr1, mv1, out1, pc1;
  logic        req0, vld0, req1, vld1;
`ifdef FETCH_STATS_EN
  logic [15:0] fc0, fl0, fc1, fl1;
`endif

  int vecs = 0;
  int errs = 0;

  always #5 clock = ~clock;

  function automatic logic [15:0] memf(input logic [15:0] a);
    case (a)
      16'd0:   memf = 16'd10;
      16'd1:   memf = 16'd5;
      16'd2:   memf = 16'd12;
      16'd3:   memf = 16'd6;
      default: memf = a * 16'd3 + 16'd7;
    endcase
  endfunction

  always @(posedge clock) begin
    mv0 <= memf(addr0);
    mv1 <= memf(addr1);
  end

  fetch_unit #(.DEPTH(4), .RESET_PC(16'h0000)) u0 (
    .clock(clock), .reset(reset), .MemGrant(MemGrant), .FetchAddr(addr0),
    .FetchReq(req0), .MemVal(mv0), .InstrOut(out0), .InstrPC(pc0),
    .InstrValid(vld0), .InstrReady(InstrReady), .Redirect(Redirect),
    .RedirectPC(RedirectPC)
`ifdef FETCH_STATS_EN
    , .FetchCount(fc0), .FlushCount(fl0)
`endif
  );

  fetch_unit #(.DEPTH(4), .RESET_PC(16'hFFFE)) u1 (
    .clock(clock), .reset(reset), .MemGrant(MemGrant), .FetchAddr(addr1),
    .FetchReq(req1), .MemVal(mv1), .InstrOut(out1), .InstrPC(pc1),
    .InstrValid(vld1), .InstrReady(InstrReady), .Redirect(Redirect),
    .RedirectPC(RedirectPC)
`ifdef FETCH_STATS_EN
    , .FetchCount(fc1), .FlushCount(fl1)
`endif
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic head(input string tag, input logic [15:0] p);
    chk({tag, "_valid"}, {15'd0, vld0}, 16'd1);
    chk({tag, "_pc"}, pc0, p);
    chk({tag, "_out"}, out0, memf(p));
  endtask

  // One clock: inputs change 1 time unit after the edge, checks follow 1 later.
  task automatic step(input logic r, input logic g, input logic rdy,
                      input logic rd, input logic [15:0] rpc);
    @(posedge clock);
    #1;
    reset = r; MemGrant = g; InstrReady = rdy; Redirect = rd; RedirectPC = rpc;
    #1;
  endtask

  initial begin
    // ---- reset state, then streaming with ready high ----
    step(1, 1, 1, 0, 0);
    step(1, 1, 1, 0, 0);
    chk("rst_req", {15'd0, req0}, 16'd0);
    chk("rst_valid", {15'd0, vld0}, 16'd0);
    chk("rst_addr", addr0, 16'h0000);
    chk("rst_out", out0, 16'h0000);
    chk("rst_pcout", pc0, 16'h0000);
    chk("rst_addr_u1", addr1, 16'hFFFE);
    step(0, 1, 1, 0, 0);  // c0
    chk("s_c0_req", {15'd0, req0}, 16'd1);
    chk("s_c0_addr", addr0, 16'h0000);
    chk("s_c0_valid", {15'd0, vld0}, 16'd0);
    step(0, 1, 1, 0, 0);  // c1
    chk("s_c1_valid", {15'd0, vld0}, 16'd0);
    step(0, 1, 1, 0, 0); head("s_c2", 16'd0);
    chk("w_c2_pc", pc1, 16'hFFFE); chk("w_c2_out", out1, memf(16'hFFFE));
    step(0, 1, 1, 0, 0); head("s_c3", 16'd1);
    chk("w_c3_pc", pc1, 16'hFFFF); chk("w_c3_out", out1, memf(16'hFFFF));
    step(0, 1, 1, 0, 0); head("s_c4", 16'd2);
    chk("w_c4_pc", pc1, 16'h0000); chk("w_c4_out", out1, 16'd10);
    step(0, 1, 1, 0, 0); head("s_c5", 16'd3);
    chk("w_c5_pc", pc1, 16'h0001); chk("w_c5_out", out1, 16'd5);

    // ---- fill to DEPTH with ready low, then drain ----
    step(1, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0);  // c0..c3
    step(0, 1, 0, 0, 0);  // c4: 3 buffered + 1 in flight
    chk("f_c4_req", {15'd0, req0}, 16'd0);
    chk("f_c4_addr", addr0, 16'd4);
    step(0, 1, 1, 0, 0);  // c5: full, pop not credited
    chk("f_c5_req", {15'd0, req0}, 16'd0);
    chk("f_c5_addr", addr0, 16'd4);
    head("f_c5", 16'd0);
`ifdef FETCH_STATS_EN
    chk("f_fetchcnt", fc0, 16'd4);
`endif
    step(0, 1, 1, 0, 0); head("f_c6", 16'd1);
    chk("f_c6_req", {15'd0, req0}, 16'd1);
    step(0, 1, 1, 0, 0); head("f_c7", 16'd2);
    chk("f_c7_addr", addr0, 16'd5);
    step(0, 1, 1, 0, 0); head("f_c8", 16'd3);
    step(0, 1, 1, 0, 0); head("f_c9", 16'd4);
    step(0, 1, 1, 0, 0); head("f_c10", 16'd5);

    // ---- redirect with 3 buffered + 1 in flight ----
    step(1, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0);
    step(0, 1, 0, 1, 16'd2);  // c4: redirect
    chk("r_c4_req", {15'd0, req0}, 16'd0);
    step(0, 1, 1, 0, 0);      // c5
    chk("r_c5_valid", {15'd0, vld0}, 16'd0);
    chk("r_c5_addr", addr0, 16'd2);
    chk("r_c5_req", {15'd0, req0}, 16'd1);
`ifdef FETCH_STATS_EN
    chk("r_flushcnt", fl0, 16'd4);
`endif
    step(0, 1, 1, 0, 0);      // c6: stale return must not appear
    chk("r_c6_valid", {15'd0, vld0}, 16'd0);
    chk("r_c6_addr", addr0, 16'd3);
    step(0, 1, 1, 0, 0); head("r_c7", 16'd2);
    step(0, 1, 1, 0, 0); head("r_c8", 16'd3);

    // ---- grant toggling 1,0,1,0 ----
    step(1, 1, 1, 0, 0);
    step(0, 1, 1, 0, 0);  // c0
    chk("g_c0_req", {15'd0, req0}, 16'd1);
    step(0, 0, 1, 0, 0);  // c1
    chk("g_c1_req", {15'd0, req0}, 16'd0);
    chk("g_c1_addr", addr0, 16'd1);
    step(0, 1, 1, 0, 0); head("g_c2", 16'd0);
    chk("g_c2_addr", addr0, 16'd1);
    step(0, 0, 1, 0, 0);  // c3
    chk("g_c3_valid", {15'd0, vld0}, 16'd0);
    chk("g_c3_addr", addr0, 16'd2);
    step(0, 1, 1, 0, 0); head("g_c4", 16'd1);
    step(0, 0, 1, 0, 0);
    chk("g_c5_valid", {15'd0, vld0}, 16'd0);
    step(0, 0, 1, 0, 0); head("g_c6", 16'd2);

    // ---- reset one cycle after an issue ----
    step(1, 1, 1, 0, 0);
    step(0, 1, 1, 0, 0);  // c0 issue
    step(1, 1, 1, 0, 0);  // c1 reset
    chk("x_c1_req", {15'd0, req0}, 16'd0);
    chk("x_c1_valid", {15'd0, vld0}, 16'd0);
    step(0, 0, 1, 0, 0);  // c2
    chk("x_c2_valid", {15'd0, vld0}, 16'd0);
    chk("x_c2_addr", addr0, 16'h0000);
    chk("x_c2_addr_u1", addr1, 16'hFFFE);
`ifdef FETCH_STATS_EN
    chk("x_fetchcnt", fc0, 16'd0);
    chk("x_flushcnt", fl0, 16'd0);
`endif
    step(0, 0, 1, 0, 0);  // c3
    chk("x_c3_valid", {15'd0, vld0}, 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
